// File: rtl/bcd_countdown.sv
// BCD down-counter with IDLE/RUN/PAUSE control.
// The count is a cascade of DIGITS BCD digits and decrements with ripple
// borrow. Load has top priority in every state and clamps digits above 9.
// When the count reaches zero the block returns to IDLE and pulses Done.
module bcd_countdown #(
    parameter int DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Din,
    input  logic                  Start,
    input  logic                  Pause,
    input  logic                  Bin,
    output logic [4*DIGITS-1:0]   q,
    output logic                  Bout,
    output logic                  Busy,
    output logic                  Done
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] COUNT_ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           done_q, done_d;

    logic [W-1:0]   decCount;
    logic [W-1:0]   loadValue;
    logic           countIsZero;
    logic           countIsOne;

    assign countIsZero = (count_q == '0);
    assign countIsOne  = (count_q == COUNT_ONE);

    // Ripple-borrow BCD decrement: a zero digit wraps to 9 and passes the
    // borrow upward, the first non-zero digit absorbs it.
    always_comb begin : decrementLogic
        logic       borrow;
        logic [3:0] digit;
        borrow   = 1'b1;
        digit    = 4'd0;
        decCount = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count_q[4*i +: 4];
            if (borrow) begin
                if (digit == 4'd0) begin
                    decCount[4*i +: 4] = 4'd9;
                end else begin
                    decCount[4*i +: 4] = digit - 4'd1;
                    borrow = 1'b0;
                end
            end else begin
                decCount[4*i +: 4] = digit;
            end
        end
    end

    // Preset clamp: any non-BCD nibble on Din is stored as 9.
    always_comb begin : loadClamp
        loadValue = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (Din[4*i +: 4] > 4'd9) begin
                loadValue[4*i +: 4] = 4'd9;
            end else begin
                loadValue[4*i +: 4] = Din[4*i +: 4];
            end
        end
    end

    // State, count and Done registers; reset aborts any countdown at once.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: Load overrides everything, Pause beats Bin in RUN,
    // and the terminal decrement drops straight back to IDLE with Done.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (Load) begin
            count_d = loadValue;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start && !countIsZero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (Pause) begin
                        state_d = PAUSE;
                    end else if (Bin && !countIsZero) begin
                        count_d = decCount;
                        if (countIsOne) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (Start) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Combinational status outputs derived from the current state and inputs.
    always_comb begin
        Busy = (state_q != IDLE);
        Bout = (state_q == RUN) && Bin && !Pause && !Load && countIsOne;
    end

    assign q    = count_q;
    assign Done = done_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed testbench for bcd_countdown (DIGITS = 4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bcd_countdown;

    logic        Clk;
    logic        Rst_n;
    logic        Load;
    logic [15:0] Din;
    logic        Start;
    logic        Pause;
    logic        Bin;
    logic [15:0] q;
    logic        Bout;
    logic        Busy;
    logic        Done;

    int assertCount;
    int failCount;

    bcd_countdown #(.DIGITS(4)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Load  (Load),
        .Din   (Din),
        .Start (Start),
        .Pause (Pause),
        .Bin   (Bin),
        .q     (q),
        .Bout  (Bout),
        .Busy  (Busy),
        .Done  (Done)
    );

    // 10-unit clock period.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Decimal to 4-digit BCD, used to build expected count values.
    function automatic logic [15:0] toBcd(input int n);
        toBcd = {4'((n / 1000) % 10), 4'((n / 100) % 10),
                 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive all control inputs at once.
    task automatic applyStimulus(input logic ld, input logic [15:0] din,
                                 input logic st, input logic ps, input logic bi);
        Load  = ld;
        Din   = din;
        Start = st;
        Pause = ps;
        Bin   = bi;
    endtask

    // One counted comparison of an observed value against an expected one.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Sequence of directed scenarios.
    initial begin
        assertCount = 0;
        failCount   = 0;
        Rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_q",    32'(q),    32'h0);
        checkOutput("reset_busy", 32'(Busy), 32'h0);
        checkOutput("reset_done", 32'(Done), 32'h0);
        checkOutput("reset_bout", 32'(Bout), 32'h0);
        tick();
        tick();
        Rst_n = 1'b1;
        tick();

        // Scenario 1: plain countdown from 12.
        $display("[TB] scenario 1: plain countdown");
        applyStimulus(1'b1, 16'h0012, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("s1_load_q",    32'(q),    32'h0012);
        checkOutput("s1_load_busy", 32'(Busy), 32'h0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("s1_start_busy", 32'(Busy), 32'h1);
        checkOutput("s1_start_q",    32'(q),    32'h0012);
        Start = 1'b0;
        for (int n = 12; n >= 1; n--) begin
            checkOutput("s1_q",    32'(q),    32'(toBcd(n)));
            checkOutput("s1_bout", 32'(Bout), (n == 1) ? 32'h1 : 32'h0);
            checkOutput("s1_done", 32'(Done), 32'h0);
            tick();
        end
        checkOutput("s1_zero_q",    32'(q),    32'h0);
        checkOutput("s1_zero_busy", 32'(Busy), 32'h0);
        checkOutput("s1_zero_done", 32'(Done), 32'h1);
        checkOutput("s1_zero_bout", 32'(Bout), 32'h0);
        tick();
        checkOutput("s1_after_done", 32'(Done), 32'h0);
        checkOutput("s1_after_q",    32'(q),    32'h0);

        // Scenario 2: multi-digit borrow 1000 -> 0999.
        $display("[TB] scenario 2: multi-digit borrow");
        applyStimulus(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("s2_bout_pre", 32'(Bout), 32'h0);
        tick();
        Bin = 1'b0;
        checkOutput("s2_q",    32'(q),    32'h0999);
        checkOutput("s2_busy", 32'(Busy), 32'h1);
        checkOutput("s2_bout", 32'(Bout), 32'h0);
        checkOutput("s2_done", 32'(Done), 32'h0);

        // Scenario 3: pause with Bin high, then resume.
        $display("[TB] scenario 3: pause/resume");
        applyStimulus(1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("s3_run_q", 32'(q), 32'h0005);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            checkOutput("s3_pause_bout", 32'(Bout), 32'h0);
            tick();
            checkOutput("s3_pause_q",    32'(q),    32'h0005);
            checkOutput("s3_pause_busy", 32'(Busy), 32'h1);
        end
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("s3_resume_q", 32'(q), 32'h0005);
        Start = 1'b0;
        tick();
        checkOutput("s3_dec_q", 32'(q), 32'h0004);

        // Scenario 4: Load with clamp while running.
        $display("[TB] scenario 4: load priority and clamp");
        applyStimulus(1'b1, 16'h0A3F, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("s4_q",    32'(q),    32'h0939);
        checkOutput("s4_busy", 32'(Busy), 32'h0);
        checkOutput("s4_done", 32'(Done), 32'h0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("s4_idle_hold_q", 32'(q), 32'h0939);
        Bin = 1'b0;

        // Scenario 5: Start with count zero after reset.
        $display("[TB] scenario 5: start at zero");
        Rst_n = 1'b0;
        #1;
        checkOutput("s5_reset_q", 32'(q), 32'h0);
        tick();
        Rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("s5_busy", 32'(Busy), 32'h0);
        checkOutput("s5_done", 32'(Done), 32'h0);
        checkOutput("s5_bout", 32'(Bout), 32'h0);
        checkOutput("s5_q",    32'(q),    32'h0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();

        // Scenario 6: asynchronous reset in the middle of a countdown.
        $display("[TB] scenario 6: reset mid-run");
        applyStimulus(1'b1, 16'h0043, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        Bin = 1'b0;
        checkOutput("s6_pre_q",    32'(q),    32'h0042);
        checkOutput("s6_pre_busy", 32'(Busy), 32'h1);
        #2;
        Rst_n = 1'b0;
        #1;
        checkOutput("s6_async_q",    32'(q),    32'h0);
        checkOutput("s6_async_busy", 32'(Busy), 32'h0);
        checkOutput("s6_async_done", 32'(Done), 32'h0);
        tick();
        checkOutput("s6_hold_done", 32'(Done), 32'h0);
        Rst_n = 1'b1;
        tick();
        checkOutput("s6_post_done", 32'(Done), 32'h0);
        checkOutput("s6_post_busy", 32'(Busy), 32'h0);
        checkOutput("s6_post_q",    32'(q),    32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bcd_countdown.md
BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 The block SHALL take one parameter:
- DIGITS, default 4, number of cascaded BCD digits (1..8).

REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- Clk, in, 1: base clock; rising edge.
- Rst_n, in, 1: reset; asynchronous, active-low.
- Load, in, 1: load preset from Din.
- Din, in, 4*DIGITS: BCD preset; digit 0 in [3:0], least significant.
- Start, in, 1: begin or resume countdown.
- Pause, in, 1: suspend countdown.
- Bin, in, 1: borrow/count-enable input; one decrement per cycle when high.
- q, out, 4*DIGITS: current BCD count.
- Bout, out, 1: borrow output; terminal decrement indicator.
- Busy, out, 1: high when not IDLE.
- Done, out, 1: single-cycle pulse after the count reaches zero.

Function
REQ-003 The block SHALL implement states IDLE, RUN and PAUSE, held in a registered state variable.

REQ-004 Load SHALL have the highest priority in every state:
- count <= Din;
- state <= IDLE;
- Done <= 0;
- Start, Pause and Bin are ignored that cycle.

REQ-005 On load, any Din digit > 9 SHALL be stored as 9; other digits are stored unchanged.

REQ-006 IDLE transitions:
- Start=1 with count != 0 -> RUN.
- Start=1 with count == 0 -> remain IDLE; no Done.

REQ-007 RUN transitions, in priority order:
- Pause=1 -> PAUSE; Pause wins over simultaneous Start and Bin; no decrement that cycle.
- Otherwise Bin=1 -> decrement.
- Otherwise hold.

REQ-008 Decrement SHALL be BCD ripple-borrow:
- digit 0 decrements by one;
- a digit at 0 receiving a borrow becomes 9 and propagates the borrow to the next digit;
- a digit > 0 absorbs the borrow.

REQ-009 A decrement from count == 1 (all digits 0 except digit 0 = 1) SHALL produce count 0 and move the state to IDLE on the same edge.

REQ-010 Done SHALL be registered:
- 1 for exactly the one cycle following the edge on which count became 0 via REQ-009;
- 0 otherwise.

REQ-011 Bout SHALL be combinational: Bout = (state==RUN) & Bin & ~Pause & ~Load & (count==1).

REQ-012 PAUSE transitions:
- Start=1 -> RUN; the first decrement can occur the cycle after the transition;
- Bin is ignored in PAUSE;
- Pause=1 held is harmless.

REQ-013 The count SHALL never decrement below 0, and SHALL never decrement in IDLE or PAUSE.

REQ-014 Busy SHALL be combinational: Busy = (state != IDLE).

REQ-015 q SHALL equal the count register directly, with no added latency.

Reset
REQ-016 While Rst_n=0, and immediately on its assertion regardless of Clk:
- count = 0;
- state = IDLE;
- Done = 0;
- Busy = 0;
- Bout = 0.

REQ-017 Reset asserted mid-RUN SHALL abort the countdown with no Done pulse; after release the block waits in IDLE for Load/Start.

REQ-018 All registers SHALL use the single Clk domain; there are no other resets.

Verification
REQ-019 Bench scenario 1 (plain countdown):
- Stimulus: DIGITS=4; Load Din=16'h0012; Start; Bin=1 continuously.
- Required response: q = 0012, 0011, 0010, 0009, ..., 0001, 0000.
- Bout=1 on the cycle q=0001.
- Done=1 on the cycle after q becomes 0000; Busy drops on that same edge.

REQ-020 Bench scenario 2 (multi-digit borrow):
- Stimulus: Load 16'h1000, Start, one Bin pulse.
- Required response: q=0999; no Bout; Busy=1.

REQ-021 Bench scenario 3 (pause/resume):
- Stimulus: in RUN at q=0005, assert Pause together with Bin=1 for 3 cycles; then Start.
- Required response: q holds 0005 throughout PAUSE.
- With Bin=1 after Start, q=0004 one cycle after the RUN transition.

REQ-022 Bench scenario 4 (load priority and clamp):
- Stimulus: Load Din=16'h0A3F while in RUN.
- Required response: q=0939; state IDLE; Busy=0.

REQ-023 Bench scenario 5 (start at zero):
- Stimulus: from reset, Start with count 0.
- Required response: stays IDLE; Done=0; Bout=0.

REQ-024 Bench scenario 6 (reset mid-run):
- Stimulus: Rst_n low mid-RUN at q=0042.
- Required response: q=0000 and Busy=0 asynchronously; no Done pulse.
